// File: rtl/scan_test_ctrl_if.sv
// scan_test_ctrl_if
// Groups the front-end request/result signals and the scan-chain pins of
// scan_test_ctrl.
//   master : test/debug front end (drives start/abort/pattern/expected/mask,
//            observes busy/done/pass/captured)
//   slave  : scan_test_ctrl itself
//   chain  : the scan chain (observes scan_en/scan_in, drives chain_so)
interface scan_test_ctrl_if #(
    parameter int unsigned CHAIN_LEN = 4
) ();
    logic                 start;
    logic                 abort;
    logic [CHAIN_LEN-1:0] pattern;
    logic [CHAIN_LEN-1:0] expected;
    logic [CHAIN_LEN-1:0] mask;
    logic                 chain_so;
    logic                 scan_en;
    logic                 scan_in;
    logic                 busy;
    logic                 done;
    logic                 pass;
    logic [CHAIN_LEN-1:0] captured;

    modport master (
        output start, abort, pattern, expected, mask,
        input  busy, done, pass, captured
    );

    modport slave (
        input  start, abort, pattern, expected, mask, chain_so,
        output scan_en, scan_in, busy, done, pass, captured
    );

    modport chain (
        input  scan_en, scan_in,
        output chain_so
    );
endinterface

// File: rtl/scan_test_ctrl.sv
// scan_test_ctrl
// Scan-test sequencer: shifts a pattern into the scan chain (LOAD), runs
// CAP_CYCLES functional clocks (CAPTURE), shifts the chain contents back out
// (UNLOAD), then reports the unloaded value and a masked compare (DONE).
// Ports:
//   clk  : single clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : scan_test_ctrl_if.slave
//            in : start, abort, pattern, expected, mask, chain_so
//            out: scan_en, scan_in (registered chain controls),
//                 busy, done, pass, captured
// Parameters:
//   CHAIN_LEN  : scan flops in the chain (>= 2)
//   CAP_CYCLES : capture clocks between load and unload (>= 1)
//   SO_DELAY   : edges from a chain shift until chain_so shows the new bit
module scan_test_ctrl #(
    parameter int unsigned CHAIN_LEN  = 4,
    parameter int unsigned CAP_CYCLES = 1,
    parameter int unsigned SO_DELAY   = 1
) (
    input logic             clk,
    input logic             rst,
    scan_test_ctrl_if.slave bus
);

    localparam int unsigned UNLOAD_LEN = CHAIN_LEN + SO_DELAY;
    localparam int unsigned CNT_MAX    = (UNLOAD_LEN > CAP_CYCLES) ? UNLOAD_LEN : CAP_CYCLES;
    localparam int unsigned CW         = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] LOAD_LAST   = CW'(CHAIN_LEN - 1);
    localparam logic [CW-1:0] CAP_LAST    = CW'(CAP_CYCLES - 1);
    localparam logic [CW-1:0] UNLOAD_LAST = CW'(UNLOAD_LEN - 1);
    localparam logic [CW-1:0] SO_FIRST    = CW'(SO_DELAY);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StCapture,
        StUnload,
        StDone
    } state_e;

    state_e               state_q;
    logic [CW-1:0]        cnt_q;
    // Shared shift register: remaining load bits during LOAD, unloaded bits
    // during UNLOAD. The MSB of each phase lives in scan_in_q / sr_shift.
    logic [CHAIN_LEN-2:0] sr_q;
    logic [CHAIN_LEN-1:0] exp_q;
    logic [CHAIN_LEN-1:0] mask_q;
    logic                 scan_en_q;
    logic                 scan_in_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 pass_q;
    logic [CHAIN_LEN-1:0] captured_q;

    // Unloaded value including the bit currently on chain_so; only meaningful
    // in the last UNLOAD cycle, where it becomes the captured result.
    logic [CHAIN_LEN-1:0] sr_shift;
    assign sr_shift = {sr_q, bus.chain_so};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            sr_q       <= '0;
            exp_q      <= '0;
            mask_q     <= '0;
            scan_en_q  <= 1'b0;
            scan_in_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            captured_q <= '0;
        end else if (bus.abort) begin
            // captured/pass were cleared at acceptance and stay that way.
            state_q   <= StIdle;
            cnt_q     <= '0;
            scan_en_q <= 1'b0;
            scan_in_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        state_q    <= StLoad;
                        cnt_q      <= '0;
                        exp_q      <= bus.expected;
                        mask_q     <= bus.mask;
                        pass_q     <= 1'b0;
                        captured_q <= '0;
                        busy_q     <= 1'b1;
                        scan_en_q  <= 1'b1;
                        // MSB goes out first so it travels to the far flop.
                        scan_in_q  <= bus.pattern[CHAIN_LEN-1];
                        sr_q       <= bus.pattern[CHAIN_LEN-2:0];
                    end
                end

                StLoad: begin
                    if (cnt_q == LOAD_LAST) begin
                        state_q   <= StCapture;
                        cnt_q     <= '0;
                        scan_en_q <= 1'b0;
                        scan_in_q <= 1'b0;
                    end else begin
                        cnt_q     <= cnt_q + CW'(1);
                        scan_in_q <= sr_q[CHAIN_LEN-2];
                        sr_q      <= sr_q << 1;
                    end
                end

                StCapture: begin
                    if (cnt_q == CAP_LAST) begin
                        state_q   <= StUnload;
                        cnt_q     <= '0;
                        scan_en_q <= 1'b1;
                        scan_in_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end

                StUnload: begin
                    // The first SO_DELAY cycles still show pre-shift data.
                    if (cnt_q >= SO_FIRST) begin
                        sr_q <= sr_shift[CHAIN_LEN-2:0];
                    end
                    if (cnt_q == UNLOAD_LAST) begin
                        state_q    <= StDone;
                        cnt_q      <= '0;
                        scan_en_q  <= 1'b0;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        captured_q <= sr_shift;
                        pass_q     <= ((sr_shift ^ exp_q) & mask_q) == '0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end

                StDone: begin
                    state_q <= StIdle;
                    cnt_q   <= '0;
                    done_q  <= 1'b0;
                end

                default: begin
                    state_q   <= StIdle;
                    cnt_q     <= '0;
                    scan_en_q <= 1'b0;
                    scan_in_q <= 1'b0;
                    busy_q    <= 1'b0;
                    done_q    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.scan_en  = scan_en_q;
    assign bus.scan_in  = scan_in_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.pass     = pass_q;
    assign bus.captured = captured_q;

endmodule
